// File: rtl/maindec_pkg.sv
// Shared opcodes, FSM state encoding and datapath select codes for the multicycle MIPS main decoder.
package maindec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP, S_JAL, S_TRAP
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_zero;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctl_t;

endpackage

// File: rtl/maindec_mc_mem_wait_ctr.sv
// Memory wait-state counter shared by FETCH/MEMRD/MEMWR; o_done flags the final cycle of an access.
module mem_wait_ctr #(
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_done = (r_cnt == CNT_W'(MEM_LAT));

endmodule

// File: rtl/maindec_mc.sv
// Multicycle MIPS main control FSM with parametrised memory wait-states.
// Define MAINDEC_EXC_EN to trap unrecognised opcodes through a one-cycle TRAP state.
module maindec_mc
  import maindec_pkg::*;
#(
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_op,
  output logic       o_pc_write,
  output logic       o_branch,
  output logic       o_branch_ne,
  output logic       o_ir_write,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_i_or_d,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op,
  output logic       o_ext_zero,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic [1:0] o_pc_src,
  output logic       o_illegal_op
);

  state_e r_state, w_next;
  ctl_t   w_ctl;
  logic   w_done, w_is_mem, w_clr;

  // Counter restarts whenever the FSM is about to leave its current state.
  assign w_is_mem = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_clr    = !w_is_mem || w_done;

  mem_wait_ctr #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) u_wait (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_clr),
    .i_en   (w_is_mem),
    .o_done (w_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    w_ctl  = '0;
    unique case (r_state)
      S_FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = SRCB_4;
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.ir_write  = w_done;
        w_ctl.pc_write  = w_done;
        w_next          = w_done ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_ctl.alu_src_b = SRCB_IMM2;
        w_ctl.alu_op    = ALU_ADD;
        case (i_op)
          OP_LW, OP_SW:                     w_next = S_MEMADR;
          OP_RTYPE:                         w_next = S_EXEC;
          OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IMMEX;
          OP_J:                             w_next = S_JUMP;
          OP_JAL:                           w_next = S_JAL;
`ifdef MAINDEC_EXC_EN
          default:                          w_next = S_TRAP;
`else
          default:                          w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALU_ADD;
        w_next          = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_ctl.i_or_d   = 1'b1;
        w_ctl.mem_read = 1'b1;
        w_next         = w_done ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = DST_RT;
        w_ctl.mem_to_reg = M2R_MDR;
      end
      S_MEMWR: begin
        // Write strobe only on the last wait cycle so an aborted access never commits.
        w_ctl.i_or_d    = 1'b1;
        w_ctl.mem_write = w_done;
        w_next          = w_done ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_op    = ALU_FUNCT;
        w_next          = S_ALUWB;
      end
      S_ALUWB: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.reg_dst   = DST_RD;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_op    = ALU_SUB;
        w_ctl.pc_src    = PCS_ALUOUT;
        w_ctl.branch    = (i_op == OP_BEQ);
        w_ctl.branch_ne = (i_op == OP_BNE);
      end
      S_IMMEX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_next          = S_IMMWB;
        case (i_op)
          OP_ANDI: begin w_ctl.alu_op = ALU_AND; w_ctl.ext_zero = 1'b1; end
          OP_ORI:  begin w_ctl.alu_op = ALU_OR;  w_ctl.ext_zero = 1'b1; end
          OP_SLTI: w_ctl.alu_op = ALU_SLT;
          default: w_ctl.alu_op = ALU_ADD;
        endcase
      end
      S_IMMWB: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.reg_dst   = DST_RT;
      end
      S_JUMP: begin
        w_ctl.pc_write = 1'b1;
        w_ctl.pc_src   = PCS_JUMP;
      end
      S_JAL: begin
        w_ctl.pc_write   = 1'b1;
        w_ctl.pc_src     = PCS_JUMP;
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = DST_R31;
        w_ctl.mem_to_reg = M2R_PC;
      end
`ifdef MAINDEC_EXC_EN
      S_TRAP: begin
        w_ctl.pc_write   = 1'b1;
        w_ctl.pc_src     = PCS_EXC;
        w_ctl.illegal_op = 1'b1;
      end
`endif
      default: w_next = S_FETCH;
    endcase
    if (!i_rst_n) w_ctl = '0;
  end

  assign o_pc_write   = w_ctl.pc_write;
  assign o_branch     = w_ctl.branch;
  assign o_branch_ne  = w_ctl.branch_ne;
  assign o_ir_write   = w_ctl.ir_write;
  assign o_mem_read   = w_ctl.mem_read;
  assign o_mem_write  = w_ctl.mem_write;
  assign o_reg_write  = w_ctl.reg_write;
  assign o_i_or_d     = w_ctl.i_or_d;
  assign o_alu_src_a  = w_ctl.alu_src_a;
  assign o_alu_src_b  = w_ctl.alu_src_b;
  assign o_alu_op     = w_ctl.alu_op;
  assign o_ext_zero   = w_ctl.ext_zero;
  assign o_reg_dst    = w_ctl.reg_dst;
  assign o_mem_to_reg = w_ctl.mem_to_reg;
  assign o_pc_src     = w_ctl.pc_src;
  assign o_illegal_op = w_ctl.illegal_op;

endmodule

// File: tb/tb_maindec_mc.sv
// Scoreboard bench for maindec_mc: two instances (MEM_LAT=0 and 3) with random instruction streams.
module tb_maindec_mc;

  typedef struct packed {
    logic       pc_write, branch, branch_ne, ir_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_zero;
    logic [1:0] reg_dst, mem_to_reg, pc_src;
    logic       illegal_op;
  } ctl_t;

  localparam logic [5:0] R = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05, ADDI = 6'h08,
                         SLTI = 6'h0a, ANDI = 6'h0c, ORI = 6'h0d, LW = 6'h23, SW = 6'h2b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [5:0] op0, op1;
  ctl_t       act0, act1;
  ctl_t       sb0[$], sb1[$], mq[$];
  int         errors = 0, checks = 0;

  logic       p0[9], p1[9];
  logic [1:0] b0[5], b1[5];
  logic [2:0] a0, a1;

  maindec_mc #(.MEM_LAT(0), .CNT_W(4)) u_lat0 (
    .i_clk(clk), .i_rst_n(rst0), .i_op(op0),
    .o_pc_write(p0[0]), .o_branch(p0[1]), .o_branch_ne(p0[2]), .o_ir_write(p0[3]),
    .o_mem_read(p0[4]), .o_mem_write(p0[5]), .o_reg_write(p0[6]), .o_i_or_d(p0[7]),
    .o_alu_src_a(p0[8]), .o_alu_src_b(b0[0]), .o_alu_op(a0), .o_ext_zero(b0[4][0]),
    .o_reg_dst(b0[1]), .o_mem_to_reg(b0[2]), .o_pc_src(b0[3]), .o_illegal_op(b0[4][1]));

  maindec_mc #(.MEM_LAT(3), .CNT_W(4)) u_lat3 (
    .i_clk(clk), .i_rst_n(rst1), .i_op(op1),
    .o_pc_write(p1[0]), .o_branch(p1[1]), .o_branch_ne(p1[2]), .o_ir_write(p1[3]),
    .o_mem_read(p1[4]), .o_mem_write(p1[5]), .o_reg_write(p1[6]), .o_i_or_d(p1[7]),
    .o_alu_src_a(p1[8]), .o_alu_src_b(b1[0]), .o_alu_op(a1), .o_ext_zero(b1[4][0]),
    .o_reg_dst(b1[1]), .o_mem_to_reg(b1[2]), .o_pc_src(b1[3]), .o_illegal_op(b1[4][1]));

  assign act0 = {p0[0], p0[1], p0[2], p0[3], p0[4], p0[5], p0[6], p0[7], p0[8],
                 b0[0], a0, b0[4][0], b0[1], b0[2], b0[3], b0[4][1]};
  assign act1 = {p1[0], p1[1], p1[2], p1[3], p1[4], p1[5], p1[6], p1[7], p1[8],
                 b1[0], a1, b1[4][0], b1[1], b1[2], b1[3], b1[4][1]};

  // Reference model: the cycle-by-cycle control word list of one instruction, appended to mq.
  task automatic model(input logic [5:0] o, input int lat);
    ctl_t c;
    for (int k = 0; k <= lat; k++) begin
      c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
      if (k == lat) begin c.ir_write = 1; c.pc_write = 1; end
      mq.push_back(c);
    end
    c = '0; c.alu_src_b = 2'b11; mq.push_back(c);
    case (o)
      LW, SW: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; mq.push_back(c);
        for (int k = 0; k <= lat; k++) begin
          c = '0; c.i_or_d = 1;
          if (o == LW) c.mem_read = 1;
          else if (k == lat) c.mem_write = 1;
          mq.push_back(c);
        end
        if (o == LW) begin c = '0; c.reg_write = 1; c.mem_to_reg = 2'b01; mq.push_back(c); end
      end
      R: begin
        c = '0; c.alu_src_a = 1; c.alu_op = 3'b010; mq.push_back(c);
        c = '0; c.reg_write = 1; c.reg_dst = 2'b01; mq.push_back(c);
      end
      BEQ, BNE: begin
        c = '0; c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_src = 2'b01;
        c.branch = (o == BEQ); c.branch_ne = (o == BNE); mq.push_back(c);
      end
      ADDI, ANDI, ORI, SLTI: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
        c.alu_op = (o == ANDI) ? 3'b011 : (o == ORI) ? 3'b100 : (o == SLTI) ? 3'b101 : 3'b000;
        c.ext_zero = (o == ANDI) || (o == ORI); mq.push_back(c);
        c = '0; c.reg_write = 1; mq.push_back(c);
      end
      J: begin c = '0; c.pc_write = 1; c.pc_src = 2'b10; mq.push_back(c); end
      JAL: begin
        c = '0; c.pc_write = 1; c.pc_src = 2'b10; c.reg_write = 1; c.reg_dst = 2'b10;
        c.mem_to_reg = 2'b10; mq.push_back(c);
      end
      default: begin
`ifdef MAINDEC_EXC_EN
        c = '0; c.pc_write = 1; c.pc_src = 2'b11; c.illegal_op = 1; mq.push_back(c);
`endif
      end
    endcase
  endtask

  // Called just after the edge on which the DUT entered FETCH.
  task automatic run_instr(input int d, input logic [5:0] o);
    int n;
    mq.delete();
    model(o, (d == 0) ? 0 : 3);
    n = mq.size();
    foreach (mq[i]) if (d == 0) sb0.push_back(mq[i]); else sb1.push_back(mq[i]);
    if (d == 0) op0 = o; else op1 = o;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stream(input int d);
    logic [5:0] dir[7] = '{LW, SW, BNE, BEQ, ORI, JAL, 6'h3f};
    logic [5:0] tbl[13] = '{R, J, JAL, BEQ, BNE, ADDI, SLTI, ANDI, ORI, LW, SW, 6'h3f, 6'h11};
    foreach (dir[i]) run_instr(d, dir[i]);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) run_instr(d, 6'($urandom));
      else run_instr(d, tbl[$urandom_range(0, 12)]);
    end
  endtask

  always @(negedge clk) begin
    ctl_t e;
    if (rst0 && sb0.size() != 0) begin
      e = sb0.pop_front(); checks++;
      if (act0 !== e) begin errors++; $display("FAIL ctl_lat0 got %h exp %h", act0, e); end
    end
    if (rst1 && sb1.size() != 0) begin
      e = sb1.pop_front(); checks++;
      if (act1 !== e) begin errors++; $display("FAIL ctl_lat3 got %h exp %h", act1, e); end
    end
  end

  task automatic chk_zero(input string nm, input ctl_t a);
    checks++;
    if (a !== '0) begin errors++; $display("FAIL %s got %h exp 0", nm, a); end
  endtask

  initial begin
    rst0 = 0; rst1 = 0; op0 = '0; op1 = '0;
    repeat (2) begin
      @(negedge clk);
      chk_zero("reset_lat0", act0);
      chk_zero("reset_lat3", act1);
    end
    @(posedge clk); #1;
    rst0 = 1; rst1 = 1;
    fork
      stream(0);
      stream(1);
    join
    // Abort a store in its second MEMWR cycle; the strobe must never have fired.
    mq.delete();
    model(SW, 3);
    for (int i = 0; i < 7; i++) sb1.push_back(mq[i]);
    op1 = SW;
    repeat (7) @(posedge clk);
    #1 rst1 = 0;
    repeat (3) begin
      @(negedge clk);
      chk_zero("abort_lat3", act1);
    end
    @(posedge clk); #1;
    rst1 = 1;
    run_instr(1, LW);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++; $display("FAIL drain got %0d/%0d exp 0/0", sb0.size(), sb1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
